// File: rtl/mul_temporal.sv
// Unary-temporal multiplier for the uSystolic PE: thermometer-coded input x rate-coded weight.
// Optional build macro EARLY_TERM_EN ends the window once the input thermometer runs out.
module mul_temporal #(
  parameter int IWIDTH = 8,
  parameter int WWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              start,
  input  logic [IWIDTH-1:0] i_data,
  input  logic [WWIDTH-1:0] w_data,
  output logic              busy,
  output logic              valid,
  output logic              prod_bit,
  output logic              sign_i,
  output logic              sign_w,
  output logic              mac_done
);

  localparam int CW = IWIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = '1;

  generate
    if (WWIDTH != IWIDTH) begin : g_width_chk
      $error("mul_temporal: WWIDTH must equal IWIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IWIDTH-1:0] mag_i_q, mag_i_d;
  logic [WWIDTH-1:0] mag_w_q, mag_w_d;
  logic              sign_i_q, sign_i_d;
  logic              sign_w_q, sign_w_d;
  logic              valid_q, valid_d;
  logic              prod_q, prod_d;
  logic              done_q, done_d;
  logic              ibit, wbit;

  // Two's-complement magnitude; the most negative value maps to 2^(IWIDTH-1).
  function automatic logic [IWIDTH-1:0] magnitude(input logic [IWIDTH-1:0] x);
    return x[IWIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    for (int k = 0; k < CW; k++) r[k] = c[CW-1-k];
    return r;
  endfunction

  assign ibit = ({1'b0, cnt_q} < mag_i_q);
  assign wbit = ({1'b0, bitrev(cnt_q)} < mag_w_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_i_d  = mag_i_q;
    mag_w_d  = mag_w_q;
    sign_i_d = sign_i_q;
    sign_w_d = sign_w_q;
    valid_d  = 1'b0;
    prod_d   = 1'b0;
    done_d   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_i_d  = magnitude(i_data);
            mag_w_d  = magnitude(w_data);
            sign_i_d = i_data[IWIDTH-1];
            sign_w_d = w_data[WWIDTH-1];
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (en) begin
`ifdef EARLY_TERM_EN
            // Only reachable with mag_i == 0: no bit is ever emitted.
            if (!ibit) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              valid_d = 1'b1;
              prod_d  = wbit;
              if (cnt_q == CNT_LAST || ({1'b0, cnt_q} + IWIDTH'(1)) >= mag_i_q) begin
                state_d = DONE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
`else
            valid_d = 1'b1;
            prod_d  = ibit & wbit;
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (en) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mag_i_q  <= '0;
      mag_w_q  <= '0;
      sign_i_q <= 1'b0;
      sign_w_q <= 1'b0;
      valid_q  <= 1'b0;
      prod_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_i_q  <= mag_i_d;
      mag_w_q  <= mag_w_d;
      sign_i_q <= sign_i_d;
      sign_w_q <= sign_w_d;
      valid_q  <= valid_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign prod_bit = prod_q;
  assign sign_i   = sign_i_q;
  assign sign_w   = sign_w_q;
  assign mac_done = done_q;

endmodule

// File: tb/tb_mul_temporal.sv
// Scoreboard bench for mul_temporal: driver queues expected window results, monitor checks at mac_done.
module tb_mul_temporal;
  localparam int L = 128;

  logic       clk;
  logic       rst_n, en, clr, start;
  logic [7:0] i_data, w_data;
  logic       busy, valid, prod_bit, sign_i, sign_w, mac_done;

  mul_temporal #(.IWIDTH(8), .WWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .start(start),
    .i_data(i_data), .w_data(w_data), .busy(busy), .valid(valid),
    .prod_bit(prod_bit), .sign_i(sign_i), .sign_w(sign_w), .mac_done(mac_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   pop;
    logic si;
    logic sw;
    int   nv;
    int   start_cyc;
    bit   chk_lat;
    int   lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Window shape in each build: number of valid bits and start-to-mac_done edges.
  function automatic int nv_of(input int mag);
`ifdef EARLY_TERM_EN
    return mag;
`else
    return L;
`endif
  endfunction

  function automatic int lat_of(input int mag);
`ifdef EARLY_TERM_EN
    return (mag == 0) ? 2 : mag + 1;
`else
    return L + 1;
`endif
  endfunction

  // Monitor
  int acc_pop = 0;
  int acc_nv  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_pop = 0;
      acc_nv  = 0;
    end else begin
      if (valid) begin
        acc_nv++;
        if (prod_bit) acc_pop++;
      end
      if (mac_done) begin
        if (sb.size() == 0) begin
          check("unexpected_mac_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("popcount", acc_pop, e.pop);
          check("valid_count", acc_nv, e.nv);
          check("sign_i", sign_i, e.si);
          check("sign_w", sign_w, e.sw);
          if (e.chk_lat) check("done_latency", cyc - e.start_cyc, e.lat);
        end
        check("valid_with_done", valid, 0);
        acc_pop = 0;
        acc_nv  = 0;
      end else if (!busy) begin
        acc_pop = 0;
        acc_nv  = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] i, input logic [7:0] w, input int pop,
                       input logic si, input logic sw, input int mag, input bit chk_lat,
                       input bit push);
    exp_t x;
    @(negedge clk);
    i_data = i;
    w_data = w;
    start  = 1'b1;
    x.pop = pop; x.si = si; x.sw = sw; x.nv = nv_of(mag);
    x.start_cyc = cyc + 1; x.chk_lat = chk_lat; x.lat = lat_of(mag);
    if (push) sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit bubbles);
    int n = 0;
    while (busy && n < 2000) begin
      if (bubbles) en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    en = 1'b1;
    check("idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_valids(input int target);
    int seen = 0;
    int n = 0;
    while (seen < target && n < 2000) begin
      @(negedge clk);
      if (valid) seen++;
      n++;
    end
    check("valid_wait_timeout", seen, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; start = 1'b0; i_data = '0; w_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_prod", prod_bit, 0);
    check("rst_sign_i", sign_i, 0);
    check("rst_sign_w", sign_w, 0);
    check("rst_done", mac_done, 0);
    repeat (3) @(negedge clk);
    check("idle_no_start", busy, 0);

    // Asynchronous reset in the middle of a window
    issue(8'h80, 8'hC0, 0, 1'b1, 1'b1, 128, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_sign_i", sign_i, 0);
    check("async_rst_sign_w", sign_w, 0);
    check("async_rst_done", mac_done, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_valid", valid, 0);

    // Directed windows
    issue(8'd127, 8'd127, 127, 1'b0, 1'b0, 127, 1'b1, 1'b1);
    wait_idle(1'b0);
    issue(8'h80, 8'd64, 64, 1'b1, 1'b0, 128, 1'b1, 1'b1);
    wait_idle(1'b0);
    issue(8'd64, 8'hC0, 32, 1'b0, 1'b1, 64, 1'b1, 1'b1);
    wait_idle(1'b0);
    issue(8'd0, 8'd100, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    wait_idle(1'b0);

    // Random en bubbles
    issue(8'd64, 8'hC0, 32, 1'b0, 1'b1, 64, 1'b0, 1'b1);
    wait_idle(1'b1);

    // mac_done deferred while en=0 in DONE
    issue(8'd64, 8'hC0, 32, 1'b0, 1'b1, 64, 1'b0, 1'b1);
    wait_valids(nv_of(64));
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_deferred", mac_done, 0);
      check("done_deferred_busy", busy, 1);
    end
    en = 1'b1;
    wait_idle(1'b0);

    // start during RUN is ignored
    issue(8'd64, 8'hC0, 32, 1'b0, 1'b1, 64, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    i_data = 8'd127; w_data = 8'd127; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);
    check("sign_w_held", sign_w, 1);

    // clr at valid cycle 50
    issue(8'h80, 8'd64, 0, 1'b1, 1'b0, 128, 1'b0, 1'b0);
    wait_valids(50);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_valid", valid, 0);
    check("clr_prod", prod_bit, 0);
    check("clr_done", mac_done, 0);
    check("clr_sign_i_kept", sign_i, 1);
    repeat (3) @(negedge clk);
    issue(8'd127, 8'd127, 127, 1'b0, 1'b0, 127, 1'b1, 1'b1);
    wait_idle(1'b0);

    // clr and start together in IDLE
    @(negedge clk);
    i_data = 8'd127; w_data = 8'd127; clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("clr_start_busy", busy, 0);
    @(negedge clk);
    check("clr_start_busy2", busy, 0);
    check("clr_start_valid", valid, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
